// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the SPI responder.
package spi_slave_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_e;

  // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol ^ cpha) == 1'b0;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a history flop producing rise/fall pulses.
module spi_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~hist_q;
  assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Oversampling SPI target with rx/tx byte handshakes.
// Optional loopback port enabled by SPI_SLAVE_RESPONDER_LOOPBACK_EN.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter logic CPOL      = 1'b1,
  parameter logic CPHA      = 1'b1,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_MISO = 1'b1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              spi_clk_i,
  input  logic              spi_mosi_i,
  input  logic              spi_cs_i,
  output logic              spi_miso_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  input  logic [BYTE_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
  ,
  input  logic              loopback_i
`endif
);

  localparam logic SAMPLE_RISE = sample_on_rise(CPOL, CPHA);
  localparam logic [BYTE_W-1:0] IDLE_BYTE = {BYTE_W{IDLE_MISO}};

  logic clk_q, clk_rise, clk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sample_edge, shift_edge, loop;

  spi_sync_edge u_sync_clk (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_clk_i),
    .q_o(clk_q), .rise_o(clk_rise), .fall_o(clk_fall)
  );
  spi_sync_edge u_sync_mosi (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_mosi_i),
    .q_o(mosi_q), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );
  spi_sync_edge u_sync_cs (
    .clk_i(sys_clk), .rst_i(sys_rst), .d_i(spi_cs_i),
    .q_o(cs_q), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  logic unused_sync;
  assign unused_sync = clk_q ^ mosi_rise ^ mosi_fall;

  assign sample_edge = SAMPLE_RISE ? clk_rise : clk_fall;
  assign shift_edge  = SAMPLE_RISE ? clk_fall : clk_rise;

`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
  assign loop = loopback_i;
`else
  assign loop = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic              first_q, first_d;
  logic              reload_q, reload_d;
  logic [BYTE_W-1:0] tx_cur;
  logic              take, take_rx;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    first_d     = first_q;
    reload_d    = reload_q;
    tx_cur      = tx_shift_q;
    take        = 1'b0;
    take_rx     = 1'b0;

    if (tx_valid_i && !hold_full_q) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    case (state_q)
      WAIT_IDLE: begin
        miso_d = IDLE_MISO;
        if (cs_q) state_d = IDLE;
      end
      IDLE: begin
        miso_d = IDLE_MISO;
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = hold_full_q ? hold_q : IDLE_BYTE;
          take       = 1'b1;
          first_d    = ~CPHA;
          reload_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d  = IDLE;
          miso_d   = IDLE_MISO;
          first_d  = 1'b0;
          reload_d = 1'b0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = MSB_FIRST ? {rx_shift_q[BYTE_W-2:0], mosi_q}
                                   : {mosi_q, rx_shift_q[BYTE_W-1:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              done_d   = 1'b1;
              reload_d = 1'b1;
            end
          end
          // The byte-boundary reload is deferred to the next shift edge so the
          // holding register is only consumed (or underrun flagged) when a byte really starts.
          if (shift_edge || first_q) begin
            first_d = 1'b0;
            if (reload_q) begin
              reload_d = 1'b0;
              take     = 1'b1;
              take_rx  = loop;
              tx_cur   = loop ? rx_shift_q : (hold_full_q ? hold_q : IDLE_BYTE);
            end
            miso_d     = MSB_FIRST ? tx_cur[BYTE_W-1] : tx_cur[0];
            tx_shift_d = MSB_FIRST ? {tx_cur[BYTE_W-2:0], IDLE_MISO}
                                   : {IDLE_MISO, tx_cur[BYTE_W-1:1]};
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (take && !take_rx) begin
      if (hold_full_q) hold_full_d = 1'b0;
      else             underrun_d  = 1'b1;
    end

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (done_q) begin
      if (rx_valid_q && !rx_ready_i) begin
        overrun_d = 1'b1;
      end else begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= IDLE_BYTE;
      miso_q      <= IDLE_MISO;
      first_q     <= 1'b0;
      reload_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      first_q     <= first_d;
      reload_q    <= reload_d;
    end
  end

  assign spi_miso_o = miso_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_ready_o = ~hold_full_q;
  assign busy_o     = (state_q == ACTIVE);
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench: mode-3 responder (default parameters) plus a mode-0 instance.
module tb_spi_slave_responder;

  localparam int H = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       mosi    = 1'b0;

  logic       sclk3 = 1'b1, cs3 = 1'b1, miso3;
  logic [7:0] rx_data3, tx_data3 = '0;
  logic       rx_valid3, rx_ready3 = 1'b1, tx_valid3 = 1'b0, tx_ready3;
  logic       busy3, overrun3, underrun3;

  logic       sclk0 = 1'b0, cs0 = 1'b1, miso0;
  logic [7:0] rx_data0, tx_data0 = '0;
  logic       rx_valid0, rx_ready0 = 1'b1, tx_valid0 = 1'b0, tx_ready0;
  logic       busy0, overrun0, underrun0;

  int tests = 0, fails = 0;
  int ov_cnt = 0, un_cnt = 0;
  logic [7:0] exp3[$];
  logic [7:0] exp0[$];

  always #5 sys_clk = ~sys_clk;

  spi_slave_responder u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_clk_i(sclk3), .spi_mosi_i(mosi), .spi_cs_i(cs3), .spi_miso_o(miso3),
    .rx_data_o(rx_data3), .rx_valid_o(rx_valid3), .rx_ready_i(rx_ready3),
    .tx_data_i(tx_data3), .tx_valid_i(tx_valid3), .tx_ready_o(tx_ready3),
    .busy_o(busy3), .overrun_o(overrun3), .underrun_o(underrun3)
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
    , .loopback_i(1'b0)
`endif
  );

  spi_slave_responder #(.CPOL(1'b0), .CPHA(1'b0)) u_dut_m0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_clk_i(sclk0), .spi_mosi_i(mosi), .spi_cs_i(cs0), .spi_miso_o(miso0),
    .rx_data_o(rx_data0), .rx_valid_o(rx_valid0), .rx_ready_i(rx_ready0),
    .tx_data_i(tx_data0), .tx_valid_i(tx_valid0), .tx_ready_o(tx_ready0),
    .busy_o(busy0), .overrun_o(overrun0), .underrun_o(underrun0)
`ifdef SPI_SLAVE_RESPONDER_LOOPBACK_EN
    , .loopback_i(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Scoreboard: every accepted rx byte must match the oldest expected byte.
  always @(negedge sys_clk) begin
    if (overrun3 === 1'b1) ov_cnt++;
    if (underrun3 === 1'b1) un_cnt++;
    if (rx_valid3 === 1'b1 && rx_ready3 === 1'b1) begin
      tests++;
      assert (exp3.size() > 0) else begin
        fails++;
        $error("FAIL rx3_extra: observed byte %0h expected none", rx_data3);
      end
      if (exp3.size() > 0) chk("rx3_data", rx_data3, exp3.pop_front());
    end
    if (rx_valid0 === 1'b1 && rx_ready0 === 1'b1) begin
      tests++;
      assert (exp0.size() > 0) else begin
        fails++;
        $error("FAIL rx0_extra: observed byte %0h expected none", rx_data0);
      end
      if (exp0.size() > 0) chk("rx0_data", rx_data0, exp0.pop_front());
    end
  end

  task automatic m3_start();
    cs3 = 1'b0;
    tick(H);
  endtask

  task automatic m3_stop();
    tick(H);
    cs3 = 1'b1;
    tick(2 * H);
  endtask

  task automatic m3_bits(input logic [7:0] mo, input logic [7:0] mi, input int nbits,
                         input bit chk_mi, input bit chk_lat, input string tag);
    for (int i = 0; i < nbits; i++) begin
      sclk3 = 1'b0;
      mosi  = mo[7-i];
      tick(H);
      if (chk_mi) chk($sformatf("%s_miso%0d", tag, i), miso3, mi[7-i]);
      sclk3 = 1'b1;
      if (chk_lat && i == 7) begin
        tick(3);
        chk("lat_cyc3", rx_valid3, 1'b0);
        tick(1);
        chk("lat_cyc4", rx_valid3, 1'b1);
        tick(H - 4);
      end else begin
        tick(H);
      end
    end
  endtask

  initial begin
    int ov0, un0;
    logic [7:0] mo0, mi0;

    tick(4);
    chk("rst_miso", miso3, 1'b1);
    chk("rst_rx_data", rx_data3, 8'h00);
    chk("rst_rx_valid", rx_valid3, 1'b0);
    chk("rst_tx_ready", tx_ready3, 1'b1);
    chk("rst_busy", busy3, 1'b0);
    chk("rst_overrun", overrun3, 1'b0);
    chk("rst_underrun", underrun3, 1'b0);
    chk("rst_miso_m0", miso0, 1'b1);
    sys_rst = 1'b0;
    tick(2 * H);

    // Mode 3, preloaded 0xA5, receive 0x3C with latency check.
    tx_data3 = 8'hA5; tx_valid3 = 1'b1;
    tick(1);
    tx_valid3 = 1'b0;
    chk("t1_tx_ready_full", tx_ready3, 1'b0);
    un0 = un_cnt;
    exp3.push_back(8'h3C);
    m3_start();
    chk("t1_busy", busy3, 1'b1);
    m3_bits(8'h3C, 8'hA5, 8, 1'b1, 1'b1, "t1");
    m3_stop();
    chk("t1_tx_ready_empty", tx_ready3, 1'b1);
    chk("t1_no_underrun", un_cnt - un0, 0);
    chk("t1_busy_end", busy3, 1'b0);

    // Two bytes with consumer stalled: second byte dropped, one overrun.
    rx_ready3 = 1'b0;
    ov0 = ov_cnt;
    exp3.push_back(8'h11);
    m3_start();
    m3_bits(8'h11, 8'hFF, 8, 1'b0, 1'b0, "t2a");
    m3_bits(8'h22, 8'hFF, 8, 1'b0, 1'b0, "t2b");
    m3_stop();
    chk("t2_rx_data_held", rx_data3, 8'h11);
    chk("t2_rx_valid_held", rx_valid3, 1'b1);
    chk("t2_overrun_pulses", ov_cnt - ov0, 1);
    rx_ready3 = 1'b1;
    tick(2);
    chk("t2_rx_valid_clear", rx_valid3, 1'b0);

    // Nothing loaded: idle-level miso and a single underrun pulse.
    un0 = un_cnt;
    exp3.push_back(8'h5A);
    m3_start();
    m3_bits(8'h5A, 8'hFF, 8, 1'b1, 1'b0, "t3");
    m3_stop();
    chk("t3_underrun_pulses", un_cnt - un0, 1);
    chk("t3_tx_ready", tx_ready3, 1'b1);

    // Partial byte discarded, next full frame clean.
    m3_start();
    m3_bits(8'hF0, 8'hFF, 5, 1'b0, 1'b0, "t4a");
    m3_stop();
    chk("t4_partial_no_valid", rx_valid3, 1'b0);
    exp3.push_back(8'h0F);
    m3_start();
    m3_bits(8'h0F, 8'hFF, 8, 1'b0, 1'b0, "t4b");
    m3_stop();

    // Reset mid-frame with cs held low: the rest of that frame is ignored.
    m3_start();
    m3_bits(8'hC3, 8'hFF, 3, 1'b0, 1'b0, "t5a");
    sys_rst = 1'b1;
    tick(2);
    sys_rst = 1'b0;
    chk("t5_busy_after_rst", busy3, 1'b0);
    chk("t5_valid_after_rst", rx_valid3, 1'b0);
    m3_bits(8'h3C, 8'hFF, 5, 1'b0, 1'b0, "t5b");
    chk("t5_busy_ignored", busy3, 1'b0);
    m3_stop();
    chk("t5_no_valid", rx_valid3, 1'b0);
    exp3.push_back(8'h81);
    m3_start();
    m3_bits(8'h81, 8'hFF, 8, 1'b0, 1'b0, "t5c");
    m3_stop();

    // Mode 0 instance: tx 0x80, rx 0x55; first bit valid before the first rising edge.
    tx_data0 = 8'h80; tx_valid0 = 1'b1;
    tick(1);
    tx_valid0 = 1'b0;
    mo0 = 8'h55;
    mi0 = 8'h80;
    exp0.push_back(8'h55);
    mosi = mo0[7];
    tick(H);
    cs0 = 1'b0;
    tick(H);
    chk("t6_busy", busy0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t6_miso%0d", i), miso0, mi0[7-i]);
      sclk0 = 1'b1;
      tick(H);
      sclk0 = 1'b0;
      if (i < 7) mosi = mo0[6-i];
      tick(H);
    end
    cs0 = 1'b1;
    tick(2 * H);
    chk("t6_miso_idle", miso0, 1'b1);

    tick(H);
    chk("rx3_pending", exp3.size(), 0);
    chk("rx0_pending", exp0.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
